// File: rtl/trdb_packet_emitter.sv
// Trace packet emitter: accepts one formatted packet per handshake and serialises it as a
// header byte {format, len} followed by the payload bytes LSB-first, with a last marker.
module trdb_packet_emitter #(
    parameter int PAYLOAD_W = 128,
    parameter int LEN_W     = 6,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pkt_valid_i,
    output logic                 pkt_ready_o,
    input  logic [1:0]           pkt_format_i,
    input  logic [PAYLOAD_W-1:0] pkt_payload_i,
    input  logic [LEN_W-1:0]     pkt_len_i,
    output logic                 byte_valid_o,
    input  logic                 byte_ready_i,
    output logic [7:0]           byte_data_o,
    output logic                 byte_last_o,
    output logic                 len_clamp_o,
    output logic [CNT_W-1:0]     pkts_sent_o
);

    localparam int                MAXB   = PAYLOAD_W / 8;
    localparam logic [LEN_W-1:0] MAXB_L = LEN_W'(MAXB);

    typedef enum logic [1:0] {
        F_OPT_EXT    = 2'd0,
        F_DIFF_DELTA = 2'd1,
        F_ADDR_ONLY  = 2'd2,
        F_SYNC       = 2'd3
    } trdb_format_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    trdb_format_e           format_q;
    logic [PAYLOAD_W-1:0]   payload_q;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       idx_q;
    logic                   accept;
    logic                   byte_hs;
    logic                   pkt_done;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d      = state_q;
        byte_valid_o = 1'b0;
        byte_data_o  = 8'h00;
        byte_last_o  = 1'b0;

        case (state_q)
            S_HEADER: begin
                byte_valid_o = 1'b1;
                byte_data_o  = {format_q, len_q[5:0]};
                byte_last_o  = (len_q == '0);
            end
            S_PAYLOAD: begin
                byte_valid_o = 1'b1;
                byte_data_o  = payload_q[7:0];
                byte_last_o  = (idx_q == len_q - LEN_W'(1));
            end
            default: ;
        endcase

        // Ready re-opens on the last byte's handshake so packets stream without a bubble.
        byte_hs     = byte_valid_o & byte_ready_i;
        pkt_done    = byte_hs & byte_last_o;
        pkt_ready_o = (state_q == S_IDLE) | pkt_done;
        accept      = pkt_valid_i & pkt_ready_o;

        if (pkt_done) begin
            state_d = accept ? S_HEADER : S_IDLE;
        end else if (state_q == S_IDLE && accept) begin
            state_d = S_HEADER;
        end else if (state_q == S_HEADER && byte_hs) begin
            state_d = S_PAYLOAD;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            format_q    <= F_OPT_EXT;
            payload_q   <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            len_clamp_o <= 1'b0;
            pkts_sent_o <= '0;
        end else begin
            state_q     <= state_d;
            len_clamp_o <= accept & (pkt_len_i > MAXB_L);

            if (accept) begin
                format_q  <= trdb_format_e'(pkt_format_i);
                payload_q <= pkt_payload_i;
                len_q     <= (pkt_len_i > MAXB_L) ? MAXB_L : pkt_len_i;
                idx_q     <= '0;
            end else if (byte_hs && state_q == S_PAYLOAD) begin
                // The current byte always sits in the low lane; shift the next one down.
                payload_q <= {8'h00, payload_q[PAYLOAD_W-1:8]};
                idx_q     <= idx_q + LEN_W'(1);
            end

            if (pkt_done) begin
                pkts_sent_o <= pkts_sent_o + CNT_W'(1);
            end
        end
    end

endmodule
